// File: rtl/mem_data_pkg.sv
// Shared types and lane helpers for the TRV-32I data-memory controller.
package mem_data_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_ILL = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_e;

   // Byte-lane write mask for a store of the given size at byte offset off.
   function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
      logic [3:0] mask;
      case (size)
         SZ_B:    mask = 4'b0001 << off;
         SZ_H:    mask = 4'b0011 << off;
         SZ_W:    mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

   // Pick the addressed byte/half out of a read word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input size_e size,
                                               input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    res = uns ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_H:    res = uns ? {16'd0, h} : {{16{h[15]}}, h};
         SZ_W:    res = word;
         default: res = 32'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_data_array.sv
// Word-organised synchronous single-port RAM with byte write enables and a
// registered read port. No reset: contents are undefined until written.
module mem_data_array #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [3:0]            be,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem_r [2**DEPTH_LOG2];

   // Byte-lane writes and read-before-write registered read on every enabled cycle.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_r[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
         rdata <= mem_r[addr];
      end
   end

endmodule

// File: rtl/mem_data_ctrl.sv
// Data-memory controller: valid/ready request and response channels around
// a byte-enabled word RAM, with sign/zero extension and error reporting.
// Optional feature macro: MEM_DATA_MISALIGN_CHECK_EN (misaligned half/word
// accesses error out instead of being aligned down).
module mem_data_ctrl
   import mem_data_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int IDX_HI = DEPTH_LOG2 + 1;

   state_e                state_r, next_state_s;
   logic                  we_r, uns_r;
   logic [XLEN-1:0]       addr_r, wdata_r;
   size_e                 size_r;
   logic                  accept_s, err_s;
   logic [1:0]            off_s;
   logic                  req_ready_r, rsp_valid_r, rsp_err_r;
   logic [XLEN-1:0]       rsp_rdata_r;
   logic                  arr_en_s;
   logic [3:0]            arr_be_s;
   logic [DEPTH_LOG2-1:0] arr_addr_s;
   logic [31:0]           arr_wdata_s, arr_rdata_s;

   assign accept_s  = req_valid & req_ready_r;
   assign req_ready = req_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

   // Request capture on the accepting handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_r    <= 1'b0;
         uns_r   <= 1'b0;
         addr_r  <= {XLEN{1'b0}};
         wdata_r <= {XLEN{1'b0}};
         size_r  <= SZ_B;
      end else if (accept_s) begin
         we_r    <= req_we;
         uns_r   <= req_unsigned;
         addr_r  <= req_addr;
         wdata_r <= req_wdata;
         size_r  <= size_e'(req_size);
      end else begin
         we_r    <= we_r;
      end
   end

   // Effective byte offset and error decode for the captured request.
   always_comb begin
      off_s = addr_r[1:0];
      err_s = (size_r == SZ_ILL) | (|addr_r[XLEN-1:DEPTH_LOG2+2]);
`ifdef MEM_DATA_MISALIGN_CHECK_EN
      if (size_r == SZ_H) begin
         err_s = err_s | addr_r[0];
      end else if (size_r == SZ_W) begin
         err_s = err_s | (|addr_r[1:0]);
      end else begin
         err_s = err_s;
      end
`else
      if (size_r == SZ_H) begin
         off_s = {addr_r[1], 1'b0};
      end else if (size_r == SZ_W) begin
         off_s = 2'b00;
      end else begin
         off_s = addr_r[1:0];
      end
`endif
   end

   // RAM port: read the addressed word at acceptance, write lanes in ACCESS.
   // The write is gated by rst so a reset landing in ACCESS drops the store.
   always_comb begin
      arr_en_s    = 1'b0;
      arr_be_s    = 4'b0000;
      arr_addr_s  = (state_r == IDLE) ? req_addr[IDX_HI:2] : addr_r[IDX_HI:2];
      case (size_r)
         SZ_B:    arr_wdata_s = {4{wdata_r[7:0]}};
         SZ_H:    arr_wdata_s = {2{wdata_r[15:0]}};
         default: arr_wdata_s = wdata_r[31:0];
      endcase
      if (accept_s) begin
         arr_en_s = 1'b1;
      end else if ((state_r == ACCESS) && we_r && !err_s && !rst) begin
         arr_en_s = 1'b1;
         arr_be_s = lane_mask(size_r, off_s);
      end else begin
         arr_en_s = 1'b0;
      end
   end

   mem_data_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
      .clk   (clk),
      .en    (arr_en_s),
      .be    (arr_be_s),
      .addr  (arr_addr_s),
      .wdata (arr_wdata_s),
      .rdata (arr_rdata_s)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next-state logic: one outstanding request at a time.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:    next_state_s = accept_s ? ACCESS : IDLE;
         ACCESS:  next_state_s = RESP;
         RESP:    next_state_s = rsp_ready ? IDLE : RESP;
         default: next_state_s = IDLE;
      endcase
   end

   // Registered handshake flags and response payload, held stable while in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= {XLEN{1'b0}};
         rsp_err_r   <= 1'b0;
      end else begin
         req_ready_r <= (next_state_s == IDLE);
         rsp_valid_r <= (next_state_s == RESP);
         if (state_r == ACCESS) begin
            rsp_rdata_r <= (we_r | err_s) ? {XLEN{1'b0}}
                                          : load_extend(arr_rdata_s, size_r, off_s, uns_r);
            rsp_err_r   <= err_s;
         end else if ((state_r == RESP) && rsp_ready) begin
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
         end else begin
            rsp_rdata_r <= rsp_rdata_r;
            rsp_err_r   <= rsp_err_r;
         end
      end
   end

endmodule

// File: tb/tb_mem_data_ctrl.sv
// Directed self-checking bench for mem_data_ctrl.
module tb_mem_data_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [1:0]  req_size = 2'b10;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = 32'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int errors = 0;
   int checks = 0;

   logic [31:0] rd;
   logic        er;
   int          lat;

   mem_data_ctrl #(.XLEN(32), .DEPTH_LOG2(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One full transaction with rsp_ready high; returns data, error and latency.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int n);
      int k;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr;
      req_size = size; req_unsigned = uns; req_wdata = wdata;
      k = 0;
      while (!req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) check("req_ready_timeout", {31'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      n = 1;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) check("rsp_valid_timeout", {31'd0, rsp_valid}, 32'd1);
      rdata = rsp_rdata;
      err   = rsp_err;
      @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);

      // Word store then load, with latency
      do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, er, lat);
      check("st_w_rdata", rd, 32'd0);
      check("st_w_err", {31'd0, er}, 32'd0);
      do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, rd, er, lat);
      check("ld_w_rdata", rd, 32'hDEADBEEF);
      check("ld_w_err", {31'd0, er}, 32'd0);
      check("ld_w_latency", lat, 32'd2);

      // Byte store into a zero word, then extensions
      do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'h0, rd, er, lat);
      do_req(1'b1, 32'h13, 2'b00, 1'b0, 32'h0000_0080, rd, er, lat);
      do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, rd, er, lat);
      check("st_b_word", rd, 32'h8000_0000);
      do_req(1'b0, 32'h13, 2'b00, 1'b0, 32'd0, rd, er, lat);
      check("ld_b_signed", rd, 32'hFFFF_FF80);
      do_req(1'b0, 32'h13, 2'b00, 1'b1, 32'd0, rd, er, lat);
      check("ld_b_unsigned", rd, 32'h0000_0080);

      // Half loads and a half store in the upper lanes
      do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'h8001_7FFE, rd, er, lat);
      do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'd0, rd, er, lat);
      check("ld_h_signed", rd, 32'hFFFF_8001);
      do_req(1'b0, 32'h10, 2'b01, 1'b1, 32'd0, rd, er, lat);
      check("ld_h_unsigned", rd, 32'h0000_7FFE);
      do_req(1'b1, 32'h14, 2'b10, 1'b0, 32'h0, rd, er, lat);
      do_req(1'b1, 32'h16, 2'b01, 1'b0, 32'h1234_ABCD, rd, er, lat);
      do_req(1'b0, 32'h14, 2'b10, 1'b0, 32'd0, rd, er, lat);
      check("st_h_word", rd, 32'hABCD_0000);

      // Errors: illegal size and out of range (aliases word 0 if unchecked)
      do_req(1'b0, 32'h10, 2'b11, 1'b0, 32'd0, rd, er, lat);
      check("ill_size_err", {31'd0, er}, 32'd1);
      check("ill_size_rdata", rd, 32'd0);
      do_req(1'b1, 32'h0, 2'b10, 1'b0, 32'h0, rd, er, lat);
      do_req(1'b1, 32'h1000, 2'b10, 1'b0, 32'h5555_5555, rd, er, lat);
      check("oor_st_err", {31'd0, er}, 32'd1);
      do_req(1'b0, 32'h1000, 2'b10, 1'b0, 32'd0, rd, er, lat);
      check("oor_ld_err", {31'd0, er}, 32'd1);
      check("oor_ld_rdata", rd, 32'd0);
      do_req(1'b0, 32'h0, 2'b10, 1'b0, 32'd0, rd, er, lat);
      check("oor_array_kept", rd, 32'd0);

      // Misaligned half and word against word 0x10 = 0x80017FFE
      do_req(1'b0, 32'h11, 2'b01, 1'b0, 32'd0, rd, er, lat);
`ifdef MEM_DATA_MISALIGN_CHECK_EN
      check("mis_h_err", {31'd0, er}, 32'd1);
      check("mis_h_rdata", rd, 32'd0);
`else
      check("mis_h_err", {31'd0, er}, 32'd0);
      check("mis_h_rdata", rd, 32'h0000_7FFE);
`endif
      do_req(1'b0, 32'h12, 2'b10, 1'b0, 32'd0, rd, er, lat);
`ifdef MEM_DATA_MISALIGN_CHECK_EN
      check("mis_w_err", {31'd0, er}, 32'd1);
      check("mis_w_rdata", rd, 32'd0);
`else
      check("mis_w_err", {31'd0, er}, 32'd0);
      check("mis_w_rdata", rd, 32'h8001_7FFE);
`endif

      // Backpressure: response held, second request ignored
      do_req(1'b1, 32'h30, 2'b10, 1'b0, 32'h1111_1111, rd, er, lat);
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30; req_size = 2'b10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
      req_size = 2'b10; req_wdata = 32'h2222_2222;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rsp_rdata", rsp_rdata, 32'h1111_1111);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_after_req_ready", {31'd0, req_ready}, 32'd1);
      check("bp_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      do_req(1'b0, 32'h30, 2'b10, 1'b0, 32'd0, rd, er, lat);
      check("bp_second_not_taken", rd, 32'h1111_1111);

      // Reset in ACCESS suppresses the pending store
      do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'hAAAA_AAAA, rd, er, lat);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
      req_size = 2'b10; req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      do_req(1'b0, 32'h20, 2'b10, 1'b0, 32'd0, rd, er, lat);
      check("mid_rst_store_dropped", rd, 32'hAAAA_AAAA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_data_ctrl.md
# mem_data_ctrl

Parametrised data-memory controller for the TRV-32I load/store path. It replaces the bidirectional-bus data memory with separate request and response channels using valid/ready handshakes. It adds byte, half and word access with sign or zero extension, store lane steering, and error reporting for illegal, out-of-range and misaligned accesses. It sits between the core's MEM stage and a word-organised synchronous RAM.

## Interface
- `XLEN`, 32: data and address width; must be 32.
- `DEPTH_LOG2`, 10: log2 of the number of words in the array.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in XLEN: byte address.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_wdata` in XLEN: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out XLEN: extended load data; 0 for stores and errors.
- `rsp_err` out 1: access rejected.

## Operation
- FSM states are IDLE, ACCESS and RESP. Only one request is outstanding at a time.
- IDLE: `req_ready`=1. When `req_valid` & `req_ready`, capture we, addr, size, unsigned and wdata, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: perform the array access, register the result and error, then go to RESP. No exit condition.
- RESP: `rsp_valid`=1, with `rsp_rdata`/`rsp_err` held stable. When `rsp_ready`=1, go to IDLE. Otherwise stay in RESP.
- Word index is `addr[DEPTH_LOG2+1:2]`. The byte offset is `addr[1:0]`.
- Error conditions:
  - size 11;
  - any of `addr[XLEN-1:DEPTH_LOG2+2]` nonzero (out of range);
  - misalignment (see Configuration).
- On error: no array write, `rsp_rdata`=0, `rsp_err`=1.
- Store lane masks:
  - byte: `4'b0001 << off`, with `wdata[7:0]` replicated to all lanes;
  - half: `4'b0011 << off`, with `wdata[15:0]` replicated to both halves;
  - word: `4'b1111`.
- Load: select the addressed byte or half from the read word, then extend to 32 bits per `req_unsigned`. A word load returns the word unchanged.
- Stores also respond, with `rsp_rdata`=0 and `rsp_err` per the error checks.
- Memory contents are not reset and are undefined until written.

## Timing
- A request handshake at edge t0 produces the array operation at edge t1 and `rsp_valid`=1 during the cycle after t1.
- Minimum turnaround is 3 cycles per access when `rsp_ready` is held high. `req_ready` returns to 1 in the cycle after the response handshake edge.
- `req_ready` is 0 in ACCESS and RESP. Requests offered then are not taken and must be held by the master.
- A store is visible to a load accepted in any later transaction; no forwarding is required.
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Reset mid-operation: `rst` asserted in ACCESS before edge t1 suppresses the pending store, since the array write enable is gated by `~rst`. Reset in RESP drops the response.

## Configuration
- `MEM_DATA_MISALIGN_CHECK_EN` defined: the following set `rsp_err`=1, with no write and `rdata`=0:
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0.
- `MEM_DATA_MISALIGN_CHECK_EN` undefined: offset bits below the access size are forced to 0, i.e. the address is aligned down. Misalignment never errors. Size 11 and out-of-range still error.

## Structure
- Package `mem_data_pkg` holds:
  - the `size_e` enum (SZ_B, SZ_H, SZ_W, SZ_ILL);
  - the `state_e` enum (IDLE, ACCESS, RESP);
  - function `lane_mask(size, off)`;
  - function `load_extend(word, size, off, uns)`.
- Sub-module `mem_data_array`: synchronous single-port RAM, `2**DEPTH_LOG2` × 32, with 4-bit byte write enable and registered read. It has no reset.

## Test plan
- Reset then idle: `rst` pulse -> `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Word store then load: store `0xDEADBEEF` to 0x10, then word load 0x10 -> `rsp_rdata`=`0xDEADBEEF`, `rsp_err`=0, `rsp_valid` 2 cycles after accept.
- Byte store and extension:
  - byte store `0x80` to 0x13 over `0x00000000` gives word `0x80000000`;
  - signed byte load 0x13 -> `0xFFFFFF80`;
  - unsigned byte load 0x13 -> `0x00000080`.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout; a second request offered meanwhile is not accepted.
- Errors:
  - size 11 -> `rsp_err`=1;
  - addr `0x00001000` with `DEPTH_LOG2`=10 -> `rsp_err`=1 and the array is unchanged;
  - half load at 0x11 -> `rsp_err`=1 with `MEM_DATA_MISALIGN_CHECK_EN`, otherwise returns the half at 0x10.
- Reset mid-store: accept a store of `0x12345678` to 0x20, assert `rst` before the ACCESS edge -> a later load of 0x20 returns the prior contents.
